data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Handshaked, parametrised data memory for the pipelined RISC-V core's MEM stage. It accepts one load/store request at a time over a valid/ready interface and inserts a configurable number of wait states. Stores support byte, half and word granularity; loads support sign/zero extension. Misaligned or illegal accesses are reported instead of being silently truncated. The MEM stage stalls on `!req_ready` and consumes results on `rsp_valid`.

## Interface
- `DATA_WIDTH`, 32: data word width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte address width.
- `MEM_SIZE`, 64: depth in words; must be a power of two, ≥2. `IDX_W = log2(MEM_SIZE)`.
- `WAIT_STATES`, 1: extra cycles per access, 0..15.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this edge if `req_valid` is also high.
- `req_we` in 1: 1 = store, 0 = load.
- `funct3` in 3: RISC-V load/store funct3.
- `addr` in `ADDR_WIDTH`: byte address.
- `wr_data` in `DATA_WIDTH`: store data; the low bytes are used for SB/SH.
- `rsp_valid` out 1: one-cycle pulse when a response is complete.
- `rd_data` out `DATA_WIDTH`: load result, registered.
- `fault` out 1: response was misaligned or illegal; valid with `rsp_valid`.

## Operation
**State machine:** IDLE, WAIT, RESP.
- `req_ready` = not `reset` and state ∈ {IDLE, RESP}.
- **Accept** (`req_valid && req_ready` at an edge): latch `req_we`, `funct3`, `addr` and `wr_data`; load the wait counter with `WAIT_STATES`.
  - If `WAIT_STATES` = 0, go to RESP.
  - Otherwise go to WAIT.
- **WAIT:** decrement the counter each edge. When the counter reaches 1, go to RESP; the access is performed on that edge.
- **RESP:** `rsp_valid` = 1 for exactly one cycle.
  - A new accept in RESP follows the accept rules above.
  - Otherwise go to IDLE.

**Access** is performed on the edge that enters RESP, using the latched request (or the live request when `WAIT_STATES` = 0).
- Word index = `addr[IDX_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo `MEM_SIZE*4`. Byte lane = `addr[1:0]`, little-endian.
- **Stores:** SB (funct3 0) writes 1 byte lane; SH (1) writes lanes {1,0} or {3,2}; SW (2) writes all 4 lanes. Other lanes are untouched. `rd_data` ← 0.
- **Loads:**
  - LB (0) / LBU (4): byte, sign- or zero-extended.
  - LH (1) / LHU (5): half, sign- or zero-extended.
  - LW (2): full word.
- **Fault** (`fault` = 1, no memory write, `rd_data` ← 0):
  - Half access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - Load funct3 ∈ {3,6,7}.
  - Store funct3 ∉ {0,1,2}.
- `rd_data` and `fault` hold their values until the next access edge.
- Memory contents are not reset and are undefined at power-up.

## Timing
- **Reset values:** state IDLE, `rsp_valid` 0, `rd_data` 0, `fault` 0, counter 0, `req_ready` 0 while `reset` is high. `req_ready` is 1 in the first cycle after `reset` falls.
- **Latency:** accept on edge k → access on edge k+`WAIT_STATES` → `rsp_valid` high in the cycle after that edge.
- **Throughput:** one access per `WAIT_STATES`+1 cycles, because acceptance is allowed in RESP.
- **Back-to-back ordering:** a store's write commits before a load accepted in its RESP cycle can access memory, so read-after-write returns new data.
- **Reset mid-operation:** abandons the request. A store not yet at its access edge is never committed, and no `rsp_valid` is produced.
- **No request in IDLE:** `req_valid` = 0 produces no state change.
- **Input stability:** request inputs are don't-care except at the accept edge.

## Test plan
- **Reset:** `WAIT_STATES`=1; hold `reset` for 2 cycles with `req_valid`=1 → no accept, `rsp_valid`=0, `rd_data`=0; `req_ready`=1 in the first cycle after release.
- **SW then LW, 0x10:** SW 0xDEADBEEF, then LW same address → `rsp_valid` 2 cycles after each accept; LW `rd_data`=0xDEADBEEF; `fault`=0.
- **Byte/half extension:** SW 0x80FF7F01 to 0x20, then:
  - LB @0x23 → 0xFFFFFF80.
  - LBU @0x23 → 0x00000080.
  - LH @0x22 → 0xFFFF80FF.
  - LHU @0x20 → 0x00007F01.
- **Partial stores:** SW 0 @0x30; SB 0xAB @0x31; SH 0x1234 @0x32; LW @0x30 → 0x1234AB00.
- **Faults:** SW @0x06 → `fault`=1 and the word at 0x04 is unchanged; LH @0x01 → `fault`=1 with `rd_data`=0; funct3=3 load → `fault`=1.
- **Wrap, `WAIT_STATES`=0:** SW 0x55 @0x100 (wraps to word 0), then LW @0x0 accepted in the RESP cycle → 0x55; `rsp_valid` in consecutive cycles.
- **Reset mid-store:** `WAIT_STATES`=3; assert `reset` 1 cycle after a SW accept → a later LW of that address returns the old value.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Handshaked data memory for the MEM stage: one request in flight, configurable
// wait states, byte/half/word stores, sign/zero-extended loads and fault reporting.
module data_mem_lsu #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_SIZE    = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  fault
);

  localparam int IDX_W     = $clog2(MEM_SIZE);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int CNT_W     = 4;
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             accept;
  logic             access;

  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;

  logic                  acc_we;
  logic [2:0]            acc_funct3;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [1:0]            acc_lane;
  logic [IDX_W-1:0]      acc_idx;
  logic                  acc_illegal;
  logic                  acc_misalign;
  logic                  acc_fault;
  logic                  unused_addr_hi;

  logic [NUM_LANES-1:0]  lane_mask;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  mem_wr;

  assign req_ready = !reset && (state_reg == ST_IDLE || state_reg == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_reg == ST_RESP);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    access     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          cnt_next = WAIT_INIT;
          if (ZERO_WAIT) begin
            state_next = ST_RESP;
            access     = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_RESP;
          access     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg      <= req_we;
      funct3_reg  <= funct3;
      addr_reg    <= addr;
      wr_data_reg <= wr_data;
    end
  end

  // With no wait states the access happens on the accept edge itself.
  assign acc_we     = ZERO_WAIT ? req_we  : we_reg;
  assign acc_funct3 = ZERO_WAIT ? funct3  : funct3_reg;
  assign acc_addr   = ZERO_WAIT ? addr    : addr_reg;
  assign acc_wdata  = ZERO_WAIT ? wr_data : wr_data_reg;

  assign acc_lane       = acc_addr[1:0];
  assign acc_idx        = acc_addr[IDX_W+1:2];
  assign unused_addr_hi = ^acc_addr[ADDR_WIDTH-1:IDX_W+2];

  always_comb begin
    acc_illegal  = acc_we ? (acc_funct3 > 3'd2)
                          : (acc_funct3 == 3'd3 || acc_funct3 >= 3'd6);
    acc_misalign = (acc_funct3[1:0] == 2'd1 && acc_addr[0]) ||
                   (acc_funct3[1:0] == 2'd2 && acc_lane != 2'd0);
  end

  assign acc_fault = acc_illegal || acc_misalign;

  // Replicate narrow store data across lanes so each lane takes its own slice.
  always_comb begin
    lane_mask = '0;
    wr_word   = acc_wdata;
    case (acc_funct3[1:0])
      2'd0: begin
        lane_mask = 4'b0001 << acc_lane;
        wr_word   = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        lane_mask = acc_lane[1] ? 4'b1100 : 4'b0011;
        wr_word   = {2{acc_wdata[15:0]}};
      end
      2'd2:    lane_mask = 4'b1111;
      default: lane_mask = '0;
    endcase
  end

  assign mem_wr = access && !reset && acc_we && !acc_fault;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_SIZE];

      always_ff @(posedge clk) begin
        if (mem_wr && lane_mask[gi]) begin
          lane_mem[acc_idx] <= wr_word[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[acc_idx];
    end
  endgenerate

  always_comb begin
    ld_byte   = rd_word[{acc_lane, 3'b000} +: 8];
    ld_half   = acc_lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (acc_funct3)
      3'd0:    load_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_data = {{16{ld_half[15]}}, ld_half};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'b0, ld_byte};
      3'd5:    load_data = {16'b0, ld_half};
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      rd_data   <= '0;
      fault     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (access) begin
        fault   <= acc_fault;
        rd_data <= (acc_we || acc_fault) ? '0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: three instances (1, 0 and 3 wait states),
// directed cases plus random traffic checked against a byte-array memory model.
module tb_data_mem_lsu;

  localparam int NDUT = 3;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  typedef struct {
    int          d;
    logic [31:0] rd;
    logic        flt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v     [NDUT];
  logic        req_valid_v [NDUT];
  logic        req_ready_v [NDUT];
  logic        rsp_valid_v [NDUT];
  logic        fault_v     [NDUT];
  logic [31:0] rd_data_v   [NDUT];
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wr_data;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  exp_t sb_q[$];
  bit [7:0] ref_mem [NDUT][256];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%08h required 0x%08h", name, d, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    data_mem_lsu #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .MEM_SIZE   (64),
      .WAIT_STATES(ws_of(gi))
    ) u_dut (
      .clk      (clk),
      .reset    (reset_v[gi]),
      .req_valid(req_valid_v[gi]),
      .req_ready(req_ready_v[gi]),
      .req_we   (req_we),
      .funct3   (funct3),
      .addr     (addr),
      .wr_data  (wr_data),
      .rsp_valid(rsp_valid_v[gi]),
      .rd_data  (rd_data_v[gi]),
      .fault    (fault_v[gi])
    );

    always @(negedge clk) begin
      exp_t e;
      if (rsp_valid_v[gi] === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp dut%0d: rsp_valid 1 with nothing outstanding, required 0", gi);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_source", gi, 32'(gi), 32'(e.d));
          chk("rsp_cycle", gi, 32'(cyc_cnt), 32'(e.cyc));
          chk("rd_data", gi, rd_data_v[gi], e.rd);
          chk("fault", gi, 32'(fault_v[gi]), 32'(e.flt));
          $display("rsp dut%0d cyc=%0d rd_data=0x%08h fault=%0d", gi, cyc_cnt, rd_data_v[gi], fault_v[gi]);
        end
      end
    end
  end

  // Reference: memory as 256 bytes, access size 1<<funct3[1:0], natural alignment.
  task automatic model(input int d, input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, output bit [31:0] rd, output bit flt);
    int base;
    int sz;
    bit legal;
    bit [31:0] v;
    base  = int'(a % 256);
    sz    = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    flt   = !legal || ((base % sz) != 0);
    rd    = '0;
    if (!flt) begin
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[d][base + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[d][base + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        rd = v;
      end
    end
  endtask

  task automatic issue(input int d, input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit use_x, input bit [31:0] x_rd,
                       input bit x_flt, input bit track);
    bit [31:0] m_rd;
    bit        m_flt;
    int        guard;
    exp_t      e;
    req_we         = we;
    funct3         = f3;
    addr           = a;
    wr_data        = wd;
    req_valid_v[d] = 1'b1;
    guard          = 0;
    while (req_ready_v[d] !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready_v[d] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout dut%0d: req_ready stuck at %0b, required 1 within 64 cycles", d, req_ready_v[d]);
      req_valid_v[d] = 1'b0;
      return;
    end
    if (track) begin
      model(d, we, f3, a, wd, m_rd, m_flt);
      e.d   = d;
      e.rd  = use_x ? x_rd : m_rd;
      e.flt = use_x ? x_flt : m_flt;
      e.cyc = cyc_cnt + 1 + ws_of(d);
      sb_q.push_back(e);
    end
    $display("req dut%0d cyc=%0d we=%0d f3=%0d addr=0x%08h wdata=0x%08h", d, cyc_cnt + 1, we, f3, a, wd);
    @(negedge clk);
    req_valid_v[d] = 1'b0;
  endtask

  task automatic req_x(input int d, input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit [31:0] x_rd, input bit x_flt);
    issue(d, we, f3, a, wd, 1'b1, x_rd, x_flt, 1'b1);
  endtask

  task automatic req_r(input int d, input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    issue(d, we, f3, a, wd, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit        we;
    bit [2:0]  f3;
    bit [31:0] a;

    for (int i = 0; i < NDUT; i++) begin
      reset_v[i]     = 1'b1;
      req_valid_v[i] = 1'b0;
    end
    req_we         = 1'b1;
    funct3         = 3'd2;
    addr           = 32'h10;
    wr_data        = 32'hCAFE_F00D;
    req_valid_v[0] = 1'b1;

    // Reset held for two cycles with a request pending
    repeat (2) begin
      @(negedge clk);
      chk("reset_ready", 0, 32'(req_ready_v[0]), 32'd0);
      chk("reset_rsp", 0, 32'(rsp_valid_v[0]), 32'd0);
      chk("reset_rd", 0, rd_data_v[0], 32'd0);
      chk("reset_fault", 0, 32'(fault_v[0]), 32'd0);
    end
    for (int i = 0; i < NDUT; i++) reset_v[i] = 1'b0;
    req_valid_v[0] = 1'b0;
    #1;
    chk("ready_after_reset", 0, 32'(req_ready_v[0]), 32'd1);
    @(negedge clk);
    chk("idle_ready", 0, 32'(req_ready_v[0]), 32'd1);
    chk("idle_rsp", 0, 32'(rsp_valid_v[0]), 32'd0);

    // One wait state: word, extension, partial stores, faults
    req_x(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    req_x(0, 0, 3'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req_x(0, 1, 3'd2, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0);
    req_x(0, 0, 3'd0, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0);
    req_x(0, 0, 3'd4, 32'h23, 32'h0, 32'h0000_0080, 1'b0);
    req_x(0, 0, 3'd1, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0);
    req_x(0, 0, 3'd5, 32'h20, 32'h0, 32'h0000_7F01, 1'b0);
    req_x(0, 1, 3'd2, 32'h30, 32'h0, 32'h0, 1'b0);
    req_x(0, 1, 3'd0, 32'h31, 32'h0000_00AB, 32'h0, 1'b0);
    req_x(0, 1, 3'd1, 32'h32, 32'h0000_1234, 32'h0, 1'b0);
    req_x(0, 0, 3'd2, 32'h30, 32'h0, 32'h1234_AB00, 1'b0);
    req_x(0, 1, 3'd2, 32'h04, 32'h1122_3344, 32'h0, 1'b0);
    req_x(0, 1, 3'd2, 32'h06, 32'hFFFF_FFFF, 32'h0, 1'b1);
    req_x(0, 0, 3'd2, 32'h04, 32'h0, 32'h1122_3344, 1'b0);
    req_x(0, 0, 3'd1, 32'h01, 32'h0, 32'h0, 1'b1);
    req_x(0, 0, 3'd3, 32'h08, 32'h0, 32'h0, 1'b1);
    drain();

    // Zero wait states: address wrap and back-to-back read-after-write
    req_x(1, 1, 3'd2, 32'h100, 32'h0000_0055, 32'h0, 1'b0);
    req_x(1, 0, 3'd2, 32'h000, 32'h0, 32'h0000_0055, 1'b0);
    drain();

    // Three wait states: reset one cycle after a store is accepted
    req_x(2, 1, 3'd2, 32'h40, 32'hAAAA_5555, 32'h0, 1'b0);
    drain();
    issue(2, 1'b1, 3'd2, 32'h40, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    reset_v[2] = 1'b1;
    @(negedge clk);
    chk("midreset_ready", 2, 32'(req_ready_v[2]), 32'd0);
    reset_v[2] = 1'b0;
    repeat (5) @(negedge clk);
    req_x(2, 0, 3'd2, 32'h40, 32'h0, 32'hAAAA_5555, 1'b0);
    drain();

    // Random traffic on every instance after filling memory with known words
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 64; w++) req_r(d, 1'b1, 3'd2, 32'(w * 4), $urandom);
      for (int n = 0; n < 120; n++) begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a  = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
        req_r(d, we, f3, a, $urandom);
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
